// File: rtl/rv_pkg.sv
// Shared RV32 core types: ALU operation encoding.
package rv_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLT = 3'd4
    } alu_operations_e;

endpackage

// File: rtl/rv_ex_issue.sv
// Execute-stage issue/retire controller: EX slot drives the combinational ALU,
// OUT slot captures the result and branch resolution for the memory stage.
module rv_ex_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [6:0]                  in_opcode_i,
    input  logic [2:0]                  in_funct3_i,
    input  logic [6:0]                  in_funct7_i,
    input  logic [XLEN-1:0]             in_rs1_i,
    input  logic [XLEN-1:0]             in_rs2_i,
    input  logic [XLEN-1:0]             in_imm_i,
    input  logic [XLEN-1:0]             in_pc_i,
    output rv_pkg::alu_operations_e     alu_ctrl_o,
    output logic [XLEN-1:0]             operand_a_o,
    output logic [XLEN-1:0]             operand_b_o,
    input  logic [XLEN-1:0]             alu_result_i,
    input  logic                        alu_zero_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [XLEN-1:0]             out_result_o,
    output logic                        out_branch_taken_o,
    output logic [XLEN-1:0]             out_branch_target_o,
    output logic                        out_illegal_o
);
    import rv_pkg::*;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // EX slot
    logic            ex_valid_q, ex_valid_d;
    alu_operations_e ex_op_q, ex_op_d;
    logic [XLEN-1:0] ex_a_q, ex_a_d;
    logic [XLEN-1:0] ex_b_q, ex_b_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic            ex_branch_q, ex_branch_d;
    logic            ex_bne_q, ex_bne_d;
    logic            ex_illegal_q, ex_illegal_d;

    // OUT slot
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic            out_taken_q, out_taken_d;
    logic [XLEN-1:0] out_target_q, out_target_d;
    logic            out_illegal_q, out_illegal_d;

    // Decoder results
    alu_operations_e dec_op;
    logic [XLEN-1:0] dec_a, dec_b;
    logic            dec_branch, dec_bne, dec_illegal;

    logic ex_advance;
    logic in_push;

    // Only funct7[5] distinguishes ADD/SUB; remaining bits are don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{in_funct7_i[6], in_funct7_i[4:0]};

    // Handshake glue; in_ready_o deliberately ignores in_valid_i and flush_i.
    always_comb begin
        ex_advance = ex_valid_q & (~out_valid_q | out_ready_i);
        in_ready_o = ~ex_valid_q | ex_advance;
        in_push    = in_valid_i & in_ready_o;
    end

    // Instruction decode into ALU op, operands and branch kind.
    always_comb begin
        dec_op      = OP_ADD;
        dec_a       = in_rs1_i;
        dec_b       = in_rs2_i;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;
        case (in_opcode_i)
            OpcR: begin
                case (in_funct3_i)
                    3'b000:  dec_op = in_funct7_i[5] ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b010:  dec_op = OP_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpcI: begin
                dec_b = in_imm_i;
                case (in_funct3_i)
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b010:  dec_op = OP_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpcLoad, OpcStore: begin
                dec_b = in_imm_i;
            end
            OpcBranch: begin
                dec_op     = OP_SUB;
                dec_branch = 1'b1;
                case (in_funct3_i)
                    3'b000:  dec_bne = 1'b0;
                    3'b001:  dec_bne = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal ops flow through as a harmless ADD 0 + 0.
        if (dec_illegal) begin
            dec_op     = OP_ADD;
            dec_a      = '0;
            dec_b      = '0;
            dec_branch = 1'b0;
            dec_bne    = 1'b0;
        end
    end

    // EX slot next state: load on push, drain on advance, squash on flush.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op_d      = ex_op_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        ex_branch_d  = ex_branch_q;
        ex_bne_d     = ex_bne_q;
        ex_illegal_d = ex_illegal_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (in_push) begin
            ex_valid_d   = 1'b1;
            ex_op_d      = dec_op;
            ex_a_d       = dec_a;
            ex_b_d       = dec_b;
            ex_pc_d      = in_pc_i;
            ex_imm_d     = in_imm_i;
            ex_branch_d  = dec_branch;
            ex_bne_d     = dec_bne;
            ex_illegal_d = dec_illegal;
        end else if (ex_advance) begin
            ex_valid_d = 1'b0;
        end
    end

    // OUT slot next state: capture ALU result on advance, clear on pop or flush.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_taken_d   = out_taken_q;
        out_target_d  = out_target_q;
        out_illegal_d = out_illegal_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (ex_advance) begin
            out_valid_d   = 1'b1;
            out_result_d  = ex_illegal_q ? '0 : alu_result_i;
            out_taken_d   = ex_branch_q & (ex_bne_q ? ~alu_zero_i : alu_zero_i);
            out_target_d  = ex_pc_q + ex_imm_q;
            out_illegal_d = ex_illegal_q;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q    <= 1'b0;
            ex_op_q       <= OP_ADD;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_pc_q       <= '0;
            ex_imm_q      <= '0;
            ex_branch_q   <= 1'b0;
            ex_bne_q      <= 1'b0;
            ex_illegal_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_taken_q   <= 1'b0;
            out_target_q  <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_op_q       <= ex_op_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_pc_q       <= ex_pc_d;
            ex_imm_q      <= ex_imm_d;
            ex_branch_q   <= ex_branch_d;
            ex_bne_q      <= ex_bne_d;
            ex_illegal_q  <= ex_illegal_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_taken_q   <= out_taken_d;
            out_target_q  <= out_target_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // ALU drive: idle EX presents a neutral ADD 0 + 0.
    always_comb begin
        alu_ctrl_o          = ex_valid_q ? ex_op_q : OP_ADD;
        operand_a_o         = ex_valid_q ? ex_a_q : '0;
        operand_b_o         = ex_valid_q ? ex_b_q : '0;
        out_valid_o         = out_valid_q;
        out_result_o        = out_result_q;
        out_branch_taken_o  = out_taken_q;
        out_branch_target_o = out_target_q;
        out_illegal_o       = out_illegal_q;
    end

endmodule

// File: tb/tb_rv_ex_issue.sv
// Directed bench for rv_ex_issue with a small behavioural ALU.
module tb_rv_ex_issue;
    import rv_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [6:0]      opcode = '0;
    logic [2:0]      funct3 = '0;
    logic [6:0]      funct7 = '0;
    logic [31:0]     rs1 = '0, rs2 = '0, imm = '0, pc = '0;
    alu_operations_e alu_ctrl;
    logic [31:0]     op_a, op_b;
    logic [31:0]     alu_res;
    logic            alu_zero;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     out_result;
    logic            out_taken;
    logic [31:0]     out_target;
    logic            out_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_ex_issue #(.XLEN(32)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_opcode_i        (opcode),
        .in_funct3_i        (funct3),
        .in_funct7_i        (funct7),
        .in_rs1_i           (rs1),
        .in_rs2_i           (rs2),
        .in_imm_i           (imm),
        .in_pc_i            (pc),
        .alu_ctrl_o         (alu_ctrl),
        .operand_a_o        (op_a),
        .operand_b_o        (op_b),
        .alu_result_i       (alu_res),
        .alu_zero_i         (alu_zero),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_result_o       (out_result),
        .out_branch_taken_o (out_taken),
        .out_branch_target_o(out_target),
        .out_illegal_o      (out_illegal)
    );

    // Behavioural ALU
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] p);
        in_valid = 1'b1;
        opcode = o; funct3 = f3; funct7 = f7;
        rs1 = a; rs2 = b; imm = i; pc = p;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 ||
            out_taken !== 1'b0 || out_target !== 32'd0 || out_illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: rdy=%b v=%b res=%h tk=%b tgt=%h ill=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_result, out_taken, out_target, out_illegal);
        end
        checks++;
        if (alu_ctrl !== OP_ADD || op_a !== 32'd0 || op_b !== 32'd0) begin
            failures++;
            $display("FAIL reset_alu: ctrl=%0d a=%h b=%h, want 0 0 0", alu_ctrl, op_a, op_b);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0, 32'd5, 32'd7, 32'd0, 32'd0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_ready: got %b want 1", in_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (alu_ctrl !== OP_ADD || op_a !== 32'd5 || op_b !== 32'd7 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_n1: ctrl=%0d a=%0d b=%0d v=%b, want 0 5 7 0",
                     alu_ctrl, op_a, op_b, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd12) begin
            failures++;
            $display("FAIL add_n2: v=%b res=%0d, want 1 12", out_valid, out_result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_pop: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_branch();
        drive(7'b1100011, 3'b000, 7'b0, 32'h1234, 32'h1234, 32'h20, 32'h100);
        tick();
        idle();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h120) begin
            failures++;
            $display("FAIL beq: v=%b tk=%b tgt=%h, want 1 1 00000120",
                     out_valid, out_taken, out_target);
        end
        tick();
        drive(7'b1100011, 3'b001, 7'b0, 32'h1234, 32'h1234, 32'h20, 32'h100);
        tick();
        idle();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_target !== 32'h120) begin
            failures++;
            $display("FAIL bne: v=%b tk=%b tgt=%h, want 1 0 00000120",
                     out_valid, out_taken, out_target);
        end
        tick();
    endtask

    task automatic test_decode();
        logic [6:0]      v_opc[6];
        logic [2:0]      v_f3[6];
        logic [6:0]      v_f7[6];
        logic [31:0]     v_a[6];
        logic [31:0]     v_b[6];
        logic [31:0]     v_i[6];
        alu_operations_e e_op[6];
        logic [31:0]     e_a[6];
        logic [31:0]     e_b[6];
        logic [31:0]     e_res[6];
        logic            e_ill[6];
        v_opc = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1100011};
        v_f3  = '{3'b000, 3'b010, 3'b111, 3'b010, 3'b001, 3'b100};
        v_f7  = '{7'b0100000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
        v_a   = '{32'd9, 32'hFFFF_FFFF, 32'hFF, 32'h1000, 32'd3, 32'd3};
        v_b   = '{32'd4, 32'd1, 32'd0, 32'd0, 32'd4, 32'd4};
        v_i   = '{32'd0, 32'd0, 32'h0F, 32'h8, 32'd0, 32'd0};
        e_op  = '{OP_SUB, OP_SLT, OP_AND, OP_ADD, OP_ADD, OP_ADD};
        e_a   = '{32'd9, 32'hFFFF_FFFF, 32'hFF, 32'h1000, 32'd0, 32'd0};
        e_b   = '{32'd4, 32'd1, 32'h0F, 32'h8, 32'd0, 32'd0};
        e_res = '{32'd5, 32'd1, 32'h0F, 32'h1008, 32'd0, 32'd0};
        e_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            drive(v_opc[k], v_f3[k], v_f7[k], v_a[k], v_b[k], v_i[k], 32'h0);
            tick();
            idle();
            #1;
            checks++;
            if (alu_ctrl !== e_op[k] || op_a !== e_a[k] || op_b !== e_b[k]) begin
                failures++;
                $display("FAIL decode_alu[%0d]: ctrl=%0d a=%h b=%h, want %0d %h %h",
                         k, alu_ctrl, op_a, op_b, e_op[k], e_a[k], e_b[k]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_result !== e_res[k] || out_illegal !== e_ill[k]) begin
                failures++;
                $display("FAIL decode_out[%0d]: v=%b res=%h ill=%b, want 1 %h %b",
                         k, out_valid, out_result, out_illegal, e_res[k], e_ill[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          sent;
        logic [31:0] got[$];
        sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 2 && cyc < 5);
            if (sent < 4) drive(7'b0010011, 3'b000, 7'b0, 32'd10, 32'd0, 32'(sent + 1), 32'd0);
            else idle();
            #1;
            if (cyc >= 2 && cyc < 5) begin
                checks++;
                if (in_ready !== 1'b0 || out_result !== 32'd11 || op_b !== 32'd2) begin
                    failures++;
                    $display("FAIL bp_stall[%0d]: rdy=%b res=%0d opb=%0d, want 0 11 2",
                             cyc, in_ready, out_result, op_b);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got.push_back(out_result);
            tick();
        end
        idle();
        out_ready = 1'b1;
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL bp_count: got %0d results want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== 32'(11 + k)) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got %0d want %0d", k, got[k], 11 + k);
                end
            end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(7'b1111111, 3'b000, 7'b0, 32'd99, 32'd98, 32'd4, 32'h40);
        tick();
        drive(7'b0110011, 3'b110, 7'b0, 32'hF0, 32'h0F, 32'd0, 32'h44);
        tick();
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'd0 ||
            out_taken !== 1'b0) begin
            failures++;
            $display("FAIL illegal: v=%b ill=%b res=%h tk=%b, want 1 1 0 0",
                     out_valid, out_illegal, out_result, out_taken);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_result !== 32'hFF) begin
            failures++;
            $display("FAIL illegal_next_or: v=%b ill=%b res=%h, want 1 0 ff",
                     out_valid, out_illegal, out_result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(7'b0110011, 3'b000, 7'b0, 32'(100 * (k + 1)), 32'd1, 32'd0, 32'd0);
            else idle();
            #1;
            if (k < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready);
                end
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== 32'(100 * (k - 1) + 1)) begin
                    failures++;
                    $display("FAIL b2b_out[%0d]: v=%b res=%0d want 1 %0d",
                             k, out_valid, out_result, 100 * (k - 1) + 1);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0, 32'd1, 32'd1, 32'd0, 32'd0);
        tick();
        drive(7'b0110011, 3'b000, 7'b0, 32'd2, 32'd2, 32'd0, 32'd0);
        tick();
        drive(7'b0110011, 3'b000, 7'b0, 32'd100, 32'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: rdy=%b v=%b, want 1 1", in_ready, out_valid);
        end
        tick();
        flush = 1'b0;
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== 32'd0) begin
            failures++;
            $display("FAIL flush_post: v=%b rdy=%b opa=%0d, want 0 1 0",
                     out_valid, in_ready, op_a);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak[%0d]: v=%b res=%0d want v=0", k, out_valid, out_result);
            end
        end
    endtask

    task automatic test_wrap_reset();
        out_ready = 1'b0;
        drive(7'b0010011, 3'b000, 7'b0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0);
        tick();
        drive(7'b0110011, 3'b000, 7'b0, 32'd3, 32'd4, 32'd0, 32'd0);
        tick();
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_target !== 32'h10 || out_result !== 32'h20 ||
            in_ready !== 1'b0) begin
            failures++;
            $display("FAIL wrap: v=%b tgt=%h res=%h rdy=%b, want 1 00000010 00000020 0",
                     out_valid, out_target, out_result, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_target !== 32'd0 ||
            out_taken !== 1'b0 || out_illegal !== 1'b0 || in_ready !== 1'b1 ||
            alu_ctrl !== OP_ADD || op_a !== 32'd0 || op_b !== 32'd0) begin
            failures++;
            $display("FAIL stall_reset: v=%b res=%h tgt=%h tk=%b ill=%b rdy=%b ctrl=%0d a=%h b=%h",
                     out_valid, out_result, out_target, out_taken, out_illegal, in_ready,
                     alu_ctrl, op_a, op_b);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_decode();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_ex_issue.md
Name: rv_ex_issue

Overview:
- Execute-stage issue/retire controller for the in-order RV32 core; sits between the decode stage and the combinational ALU.
- Accepts a decoded instruction over a valid/ready handshake and registers it. Derives the rv_pkg::alu_operations_e code and both operands, and drives them to the ALU.
- Captures the ALU result and zero flag into an output register with branch resolution, and hands off to the memory stage over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  squash both pipeline slots; takes priority over every handshake
- in_valid_i  in  1  decoded instruction valid
- in_ready_o  out  1  block can accept an instruction
- in_opcode_i  in  7  instr[6:0]
- in_funct3_i  in  3  instr[14:12]
- in_funct7_i  in  7  instr[31:25]
- in_rs1_i  in  32  rs1 value
- in_rs2_i  in  32  rs2 value
- in_imm_i  in  32  sign-extended immediate
- in_pc_i  in  32  instruction PC
- alu_ctrl_o  out  rv_pkg::alu_operations_e  ALU operation
- operand_a_o  out  32  ALU operand A
- operand_b_o  out  32  ALU operand B
- alu_result_i  in  32  ALU result, combinational from the ALU outputs above
- alu_zero_i  in  1  ALU zero flag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  memory stage accepts
- out_result_o  out  32  registered ALU result
- out_branch_taken_o  out  1  branch resolved taken
- out_branch_target_o  out  32  pc + imm, modulo 2^32
- out_illegal_o  out  1  unsupported opcode/funct

Behaviour:
- Two register slots:
  - EX: decoded op, operands, pc, imm, valid.
  - OUT: result, taken, target, illegal, valid.
- Reset (rst_i=1 at a clock edge):
  - ex_valid=0, out_valid_o=0, out_result_o=0, out_branch_taken_o=0, out_branch_target_o=0, out_illegal_o=0.
  - Because ex_valid=0 after reset: in_ready_o=1, alu_ctrl_o=OP_ADD, operand_a_o=0, operand_b_o=0.
  - Reset mid-operation drops any in-flight instruction.
- Handshakes:
  - in_ready_o = !ex_valid | ex_advance.
  - ex_advance = ex_valid & (!out_valid_o | out_ready_i).
  - in_ready_o must not depend on in_valid_i.
  - Input transfer occurs on in_valid_i & in_ready_o.
  - Output transfer occurs on out_valid_o & out_ready_i.
  - Full throughput: one instruction per cycle when out_ready_i is held at 1.
- Latency: input handshake in cycle N -> ALU driven during cycle N+1 -> out_valid_o=1 from cycle N+2.
- Stall: while out_valid_o=1 and out_ready_i=0, OUT and EX hold and ALU outputs stay stable.
- Simultaneous output pop, EX advance and input push in one cycle: all three occur; no bubble.
- Decode, registered into EX on input transfer:
  - opcode 0110011 (R-type):
    - f3=000: f7[5]=0 -> OP_ADD, f7[5]=1 -> OP_SUB
    - f3=111 -> OP_AND; f3=110 -> OP_OR; f3=010 -> OP_SLT
    - A=rs1, B=rs2
  - opcode 0010011 (I-type): f3 000/111/110/010 -> ADD/AND/OR/SLT; A=rs1, B=imm.
  - opcode 0000011 / 0100011 (load/store): OP_ADD, A=rs1, B=imm (address).
  - opcode 1100011 (branch): OP_SUB, A=rs1, B=rs2.
    - f3=000 (BEQ): taken = alu_zero_i.
    - f3=001 (BNE): taken = !alu_zero_i.
  - Any other opcode/funct combination:
    - illegal=1, OP_ADD with operands 0, result 0, taken 0.
    - Still flows through the pipeline (no hang).
- OUT load on ex_advance:
  - result = alu_result_i
  - taken as above; forced 0 for non-branch
  - target = pc + imm, 32-bit wrap; computed for all ops
  - illegal bit copied from EX
- SLT semantics are whatever the ALU returns; this block passes alu_result_i through unmodified.
- flush_i=1:
  - Next cycle ex_valid=0 and out_valid_o=0.
  - An input offered in the same cycle is discarded.
  - in_ready_o is unaffected by flush_i.
- rst_i has priority over flush_i.

Test Plan:
- Reset then ADD: rs1=5, rs2=7, opcode 0110011, f3=000, f7=0 -> alu_ctrl_o=OP_ADD in cycle N+1, out_result_o=12 and out_valid_o=1 in cycle N+2.
- BEQ: rs1=rs2=0x1234, pc=0x100, imm=0x20 -> out_branch_taken_o=1, target=0x120. Same op with BNE -> taken=0.
- Backpressure: stream 4 ADDI ops (imm=1..4, rs1=10), hold out_ready_i=0 for 3 cycles -> in_ready_o=0 while both slots are full; after release, results 11, 12, 13, 14 appear in order with no loss or duplication.
- Illegal: opcode 1111111 -> out_illegal_o=1, result 0, taken 0; the next legal op (OR 0xF0|0x0F) yields 0xFF.
- Flush: with both slots full, assert flush_i together with in_valid_i -> next cycle out_valid_o=0 and ex_valid=0; the offered instruction never appears at the output.
- Wrap: pc=0xFFFF_FFF0, imm=0x20 -> target=0x0000_0010. Apply rst_i during a stalled output -> all outputs at their reset values the following cycle.
